// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready register-file slave port among NUM_MASTERS
// requesters. A read keeps its grant through the cycle the slave's registered data returns.
module reg_bus_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_WIDTH  = 4,
   parameter int DATA_WIDTH  = 32,
   localparam int IDX_W      = $clog2(NUM_MASTERS)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_MASTERS-1:0]            m_valid,
   input  logic [NUM_MASTERS-1:0]            m_write,
   input  logic [NUM_MASTERS-1:0]            m_read,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
   output logic [NUM_MASTERS-1:0]            m_ready,
   output logic [NUM_MASTERS-1:0]            m_rvalid,
   output logic [DATA_WIDTH-1:0]             m_rdata,
   output logic                              s_valid,
   input  logic                              s_ready,
   output logic                              s_write,
   output logic                              s_read,
   output logic [ADDR_WIDTH-1:0]             s_addr,
   output logic [DATA_WIDTH-1:0]             s_wdata,
   input  logic [DATA_WIDTH-1:0]             s_rdata,
   output logic [IDX_W-1:0]                  grant_idx,
   output logic                              busy
);

   typedef enum logic [1:0] {IDLE, GRANT, RDWAIT} state_t;

   state_t                  state, state_nxt;
   logic [IDX_W-1:0]        grant_nxt;
   logic [IDX_W-1:0]        pick;
   logic [IDX_W-1:0]        cand;
   logic                    pick_found;
   logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_MASTERS];
   logic [DATA_WIDTH-1:0]   wdata_arr [NUM_MASTERS];
   logic                    g_valid, g_write, g_rd_only;

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
      assign addr_arr[i]  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[i] = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign g_valid   = m_valid[grant_idx];
   assign g_write   = m_write[grant_idx];
   // a request carrying both strobes is executed as a write
   assign g_rd_only = m_read[grant_idx] & ~m_write[grant_idx];
   assign busy      = (state != IDLE);

   // first requester strictly after the last grant, wrapping; the last winner ranks lowest
   always_comb begin
      pick       = grant_idx;
      cand       = '0;
      pick_found = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         cand = IDX_W'((int'(grant_idx) + k) % NUM_MASTERS);
         if (!pick_found && m_valid[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_idx;
      s_valid   = 1'b0;
      s_write   = 1'b0;
      s_read    = 1'b0;
      s_addr    = '0;
      s_wdata   = '0;
      m_ready   = '0;
      m_rvalid  = '0;
      m_rdata   = '0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               grant_nxt = pick;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            s_valid            = g_valid;
            s_write            = g_write;
            s_read             = g_rd_only;
            s_addr             = addr_arr[grant_idx];
            s_wdata            = wdata_arr[grant_idx];
            m_ready[grant_idx] = s_ready;
            // a dropped request abandons the grant without a transaction
            if (!g_valid)
               state_nxt = IDLE;
            else if (s_ready)
               state_nxt = g_rd_only ? RDWAIT : IDLE;
         end
         RDWAIT: begin
            m_rdata             = s_rdata;
            m_rvalid[grant_idx] = 1'b1;
            state_nxt           = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         grant_idx <= IDX_W'(NUM_MASTERS - 1);
      end else begin
         state     <= state_nxt;
         grant_idx <= grant_nxt;
      end
   end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: per-master request drivers, a behavioural slave,
// a round-robin reference model and a monitor that checks every handshake and read return.
module tb_reg_bus_arbiter;
   localparam int NM = 4;
   localparam int AW = 4;
   localparam int DW = 32;
   localparam int IW = 2;

   typedef struct packed {
      logic [1:0]    kind;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } cmd_t;

   localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_BOTH = 2'd2, K_NONE = 2'd3;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [NM-1:0]     m_valid, m_write, m_read;
   logic [NM*AW-1:0]  m_addr;
   logic [NM*DW-1:0]  m_wdata;
   logic [NM-1:0]     m_ready, m_rvalid;
   logic [DW-1:0]     m_rdata;
   logic              s_valid, s_ready, s_write, s_read;
   logic [AW-1:0]     s_addr;
   logic [DW-1:0]     s_wdata, s_rdata;
   logic [IW-1:0]     grant_idx;
   logic              busy;

   reg_bus_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .m_valid(m_valid), .m_write(m_write), .m_read(m_read), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .s_valid(s_valid), .s_ready(s_ready), .s_write(s_write), .s_read(s_read),
      .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
      .grant_idx(grant_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   cmd_t          cmd_q  [NM][$];
   cmd_t          exp_q  [NM][$];
   logic [DW-1:0] rd_exp [NM][$];
   int            rd_hs_cyc [NM];
   int            last_hs [NM];
   int            prev_hs [NM];
   int            issue_cyc [NM];
   int            hs_order [$];
   int            rv_count = 0;
   logic [DW-1:0] last_rdata = '0;
   logic [NM-1:0] active = '0;
   logic [NM-1:0] rdy_seen = '0;
   logic [DW-1:0] ref_mem [16];
   logic [DW-1:0] slave_mem [16];
   logic          sl_hs = 1'b0, sl_wr = 1'b0, sl_rd = 1'b0;
   logic [AW-1:0] sl_addr = '0;
   logic [DW-1:0] sl_wdata = '0;
   int            last_g = NM - 1;
   int            exp_g = 0;
   bit            arb_pend = 0;
   int            sready_mode = 0;
   bit            gaps = 0;
   bit            rd_hs_seen = 0;
   cmd_t          mon_e;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic cmd_t mk(input logic [1:0] k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_t c;
      c.kind = k;
      c.addr = a;
      c.data = d;
      return c;
   endfunction

   function automatic bit all_empty();
      for (int i = 0; i < NM; i++)
         if (cmd_q[i].size() != 0 || exp_q[i].size() != 0 || rd_exp[i].size() != 0) return 0;
      return 1;
   endfunction

   // present one queued command from master i; the expected outcome is recorded now
   task automatic issue(input int i);
      cmd_t c, e;
      c = cmd_q[i].pop_front();
      e = c;
      m_valid[i] = 1'b1;
      m_write[i] = (c.kind == K_WR) || (c.kind == K_BOTH);
      m_read[i]  = (c.kind == K_RD) || (c.kind == K_BOTH);
      m_addr[i*AW +: AW]  = c.addr;
      m_wdata[i*DW +: DW] = c.data;
      if (m_write[i]) ref_mem[c.addr] = c.data;
      else if (c.kind == K_RD) e.data = ref_mem[c.addr];
      exp_q[i].push_back(e);
      active[i]    = 1'b1;
      issue_cyc[i] = cyc;
   endtask

   // driver: masters hold a request until accepted; behavioural slave updates on handshake
   initial begin
      m_valid = '0; m_write = '0; m_read = '0; m_addr = '0; m_wdata = '0;
      s_ready = 1'b0; s_rdata = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (!reset) begin
            if (sl_hs) begin
               if (sl_wr) slave_mem[sl_addr] = sl_wdata;
               else if (sl_rd) s_rdata = slave_mem[sl_addr];
            end
            for (int i = 0; i < NM; i++) begin
               if (active[i] && rdy_seen[i]) begin
                  active[i] = 1'b0; m_valid[i] = 1'b0; m_write[i] = 1'b0; m_read[i] = 1'b0;
               end
               if (!active[i] && cmd_q[i].size() > 0 && (!gaps || $urandom_range(0, 2) == 0))
                  issue(i);
            end
            case (sready_mode)
               0:       s_ready = 1'b1;
               1:       s_ready = ($urandom_range(0, 3) != 0);
               default: s_ready = 1'b0;
            endcase
         end
         sl_hs    = 1'b0;
         rdy_seen = '0;
      end
   end

   always @(negedge clk) begin
      if (!reset && s_valid && s_ready) begin
         sl_hs = 1'b1; sl_wr = s_write; sl_rd = s_read; sl_addr = s_addr; sl_wdata = s_wdata;
      end
   end

   // monitor: round-robin reference, handshake scoreboard, read-return scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (reset) continue;
         if (arb_pend) begin
            chk("arb_busy", busy, 1);
            chk("arb_grant", grant_idx, exp_g);
            last_g   = exp_g;
            arb_pend = 0;
         end
         if (!busy) begin
            chk("idle_outputs", {s_valid, s_write, s_read, s_addr, s_wdata, m_ready, m_rvalid, m_rdata}, 0);
            for (int k = 1; k <= NM; k++)
               if (!arb_pend && m_valid[(last_g + k) % NM]) begin
                  exp_g    = (last_g + k) % NM;
                  arb_pend = 1;
               end
         end
         chk("ready_onehot", $countones(m_ready) <= 1, 1);
         chk("rvalid_onehot", $countones(m_rvalid) <= 1, 1);
         for (int i = 0; i < NM; i++) begin
            if (m_ready[i] && m_valid[i]) begin
               chk("hs_owner", grant_idx, i);
               chk("hs_pending", exp_q[i].size() > 0, 1);
               if (exp_q[i].size() > 0) begin
                  mon_e = exp_q[i].pop_front();
                  chk("hs_svalid", s_valid, 1);
                  chk("hs_write", s_write, (mon_e.kind == K_WR) || (mon_e.kind == K_BOTH));
                  chk("hs_read", s_read, mon_e.kind == K_RD);
                  chk("hs_addr", s_addr, mon_e.addr);
                  if (mon_e.kind == K_WR || mon_e.kind == K_BOTH) chk("hs_wdata", s_wdata, mon_e.data);
                  if (mon_e.kind == K_RD) begin
                     rd_exp[i].push_back(mon_e.data);
                     rd_hs_cyc[i] = cyc;
                     rd_hs_seen   = 1;
                  end
               end
               rdy_seen[i] = 1'b1;
               prev_hs[i]  = last_hs[i];
               last_hs[i]  = cyc;
               hs_order.push_back(i);
            end
            if (m_rvalid[i]) begin
               rv_count++;
               last_rdata = m_rdata;
               chk("rv_pending", rd_exp[i].size() > 0, 1);
               if (rd_exp[i].size() > 0) begin
                  chk("rv_data", m_rdata, rd_exp[i].pop_front());
                  chk("rv_latency", cyc - rd_hs_cyc[i], 1);
               end
            end
         end
      end
   end

   task automatic check_reset_state();
      chk("rst_outputs", {s_valid, s_write, s_read, s_addr, s_wdata, m_ready, m_rvalid, m_rdata}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant_idx, NM - 1);
   endtask

   task automatic flush_model();
      for (int i = 0; i < NM; i++) begin
         exp_q[i].delete();
         rd_exp[i].delete();
      end
      active = '0; m_valid = '0; m_write = '0; m_read = '0;
      last_g = NM - 1; arb_pend = 0;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check_reset_state();
      flush_model();
      @(posedge clk);
      #3 reset = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      bit done = 0;
      for (int n = 0; n < max_cyc && !done; n++) begin
         @(negedge clk);
         #1;
         done = !busy && (active == '0) && all_empty();
      end
      chk("drain", done, 1);
   endtask

   initial begin
      logic [AW-1:0] a0;
      logic [DW-1:0] w0;
      for (int a = 0; a < 16; a++) begin
         ref_mem[a] = '0;
         slave_mem[a] = '0;
      end
      repeat (2) @(posedge clk);
      #2 check_reset_state();
      flush_model();
      @(posedge clk);
      #3 reset = 1'b0;

      // single write from master 2
      hs_order.delete();
      cmd_q[2].push_back(mk(K_WR, 4'd5, 32'hDEADBEEF));
      wait_idle(50);
      chk("t1_latency", last_hs[2] - issue_cyc[2], 1);
      chk("t1_slave_mem", slave_mem[5], 32'hDEADBEEF);
      chk("t1_order", (hs_order.size() == 1) && (hs_order[0] == 2), 1);

      // read-back by master 1
      rv_count = 0;
      cmd_q[1].push_back(mk(K_RD, 4'd5, 32'h0));
      wait_idle(50);
      chk("t2_rvalid_count", rv_count, 1);
      chk("t2_rdata", last_rdata, 32'hDEADBEEF);

      // full contention from a fresh reset
      pulse_reset();
      hs_order.delete();
      for (int i = 0; i < NM; i++)
         for (int r = 0; r < 2; r++)
            cmd_q[i].push_back(mk(K_WR, 4'(8 + i), 32'h1000_0000 + 32'(i * 16 + r)));
      wait_idle(100);
      chk("t3_count", hs_order.size(), 2 * NM);
      for (int k = 0; k < hs_order.size() && k < 2 * NM; k++) chk("t3_order", hs_order[k], k % NM);
      for (int i = 0; i < NM; i++) chk("t3_period", last_hs[i] - prev_hs[i], 8);

      // slave stall with master 3 granted
      sready_mode = 2;
      cmd_q[3].push_back(mk(K_WR, 4'd9, 32'hA5A5_0003));
      for (int n = 0; n < 20 && !(busy && grant_idx == 2'd3); n++) begin
         @(negedge clk);
         #1;
      end
      chk("t4_granted", busy && (grant_idx == 2'd3), 1);
      a0 = s_addr;
      w0 = s_wdata;
      repeat (5) begin
         @(negedge clk);
         #1;
         chk("t4_addr_stable", s_addr, a0);
         chk("t4_wdata_stable", s_wdata, w0);
         chk("t4_no_ready", m_ready, 0);
      end
      sready_mode = 0;
      @(negedge clk);
      #1 chk("t4_complete", last_hs[3], cyc);
      wait_idle(50);
      chk("t4_slave_mem", slave_mem[9], 32'hA5A5_0003);

      // write and read strobes together behave as a write
      rv_count = 0;
      cmd_q[0].push_back(mk(K_BOTH, 4'd3, 32'h12));
      wait_idle(50);
      chk("t5_slave_mem", slave_mem[3], 32'h12);
      chk("t5_no_rvalid", rv_count, 0);

      // reset while the read data is being returned
      rd_hs_seen = 0;
      cmd_q[0].push_back(mk(K_RD, 4'd3, 32'h0));
      for (int n = 0; n < 20 && !rd_hs_seen; n++) begin
         @(negedge clk);
         #1;
      end
      chk("t6_read_hs", rd_hs_seen, 1);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 check_reset_state();
      flush_model();
      @(posedge clk);
      #3 reset = 1'b0;
      hs_order.delete();
      cmd_q[2].push_back(mk(K_RD, 4'd6, 32'h0));
      cmd_q[0].push_back(mk(K_WR, 4'd4, 32'h0BAD_F00D));
      wait_idle(50);
      chk("t6_first_after_reset", (hs_order.size() == 2) && (hs_order[0] == 0) && (hs_order[1] == 2), 1);

      // randomized traffic; each master owns the addresses whose low bits equal its index
      gaps = 1;
      sready_mode = 1;
      for (int i = 0; i < NM; i++)
         for (int r = 0; r < 60; r++) begin
            int k;
            k = $urandom_range(0, 9);
            cmd_q[i].push_back(mk((k < 5) ? K_WR : (k < 8) ? K_RD : (k == 8) ? K_BOTH : K_NONE,
                                  {2'($urandom_range(0, 3)), 2'(i)}, $urandom));
         end
      wait_idle(20000);
      for (int a = 0; a < 16; a++) chk("final_mem", slave_mem[a], ref_mem[a]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
